// File: rtl/sram_ctrl_pkg.sv
// Shared types and FSM state encoding for the SRAM controller.
package sram_ctrl_pkg;

  typedef logic [31:0] Word_t;
  typedef logic [19:0] Ram_addr_t;
  typedef logic [3:0]  Mask_t;
  typedef logic        Bit_t;

  typedef logic [2:0] sram_state_t;

  localparam sram_state_t StIdle    = 3'd0;
  localparam sram_state_t StRd      = 3'd1;
  localparam sram_state_t StWrSetup = 3'd2;
  localparam sram_state_t StWrPulse = 3'd3;
  localparam sram_state_t StWrHold  = 3'd4;
  localparam sram_state_t StDone    = 3'd5;

  // Active-low byte enables with every lane deselected.
  localparam Mask_t BeNoneN = 4'b1111;

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU-side request/response bus of the SRAM controller.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  Bit_t  req;
  Bit_t  req_we;
  Word_t req_addr;
  Mask_t req_be;
  Word_t req_wdata;
  Word_t rdata;
  Bit_t  ready;
  Bit_t  busy;

  modport master (
    output req, req_we, req_addr, req_be, req_wdata,
    input  rdata, ready, busy
  );

  modport slave (
    input  req, req_we, req_addr, req_be, req_wdata,
    output rdata, ready, busy
  );

endinterface

// File: rtl/sram_ctrl.sv
// Single-word bus requests to asynchronous SRAM cycles with programmable pulse widths.
// Define SRAM_CTRL_READ_CACHE_EN to add a one-entry read cache.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  sram_ctrl_if.slave       bus,
  inout  wire       [31:0] ram_data,
  output Ram_addr_t        ram_addr,
  output Mask_t            ram_be_n,
  output Bit_t             ram_ce_n,
  output Bit_t             ram_oe_n,
  output Bit_t             ram_we_n
);

  localparam int unsigned MaxCycles = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t RdLast = cnt_t'(READ_CYCLES - 1);
  localparam cnt_t WrLast = cnt_t'(WRITE_CYCLES - 1);

  sram_state_t state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  Ram_addr_t   addr_q;
  Mask_t       be_q;
  Word_t       wdata_q;
  Word_t       rdata_q;

  Bit_t  ce_n_q, oe_n_q, we_n_q, drive_q;
  Mask_t be_n_q;
  Bit_t  ce_n_d, oe_n_d, we_n_d, drive_d;
  Mask_t be_n_d;
  Mask_t be_sel;

  Bit_t      accept;
  Bit_t      capture;
  Bit_t      hit;
  Ram_addr_t req_word;

  // Byte offset and bits above 4 MB play no part in the SRAM address.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr[31:22], bus.req_addr[1:0]};
  assign req_word         = bus.req_addr[21:2];

`ifdef SRAM_CTRL_READ_CACHE_EN
  Bit_t      c_valid_q;
  Ram_addr_t c_tag_q;
  Word_t     c_word_q;

  assign hit = c_valid_q && (c_tag_q == req_word);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (bus.req_we) begin
            state_d = StWrSetup;
          end else if (hit) begin
            state_d = StDone;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (cnt_q == RdLast) begin
          state_d = StDone;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrSetup: begin
        state_d = StWrPulse;
        cnt_d   = '0;
      end
      StWrPulse: begin
        if (cnt_q == WrLast) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrHold: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Pin values are decoded from the state being entered so they register glitch-free.
  always_comb begin
    be_sel  = accept ? bus.req_be : be_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = BeNoneN;
    drive_d = 1'b0;
    case (state_d)
      StRd: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
      end
      StWrSetup, StWrHold: begin
        ce_n_d  = 1'b0;
        be_n_d  = ~be_sel;
        drive_d = 1'b1;
      end
      StWrPulse: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        be_n_d  = ~be_sel;
        drive_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= BeNoneN;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      drive_q <= drive_d;
      if (accept) begin
        addr_q  <= req_word;
        be_q    <= bus.req_be;
        wdata_q <= bus.req_wdata;
      end
      if (capture) begin
        rdata_q <= ram_data;
      end
`ifdef SRAM_CTRL_READ_CACHE_EN
      else if (accept && !bus.req_we && hit) begin
        rdata_q <= c_word_q;
      end
`endif
    end
  end

`ifdef SRAM_CTRL_READ_CACHE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      c_valid_q <= 1'b0;
      c_tag_q   <= '0;
      c_word_q  <= '0;
    end else if (capture) begin
      c_valid_q <= 1'b1;
      c_tag_q   <= addr_q;
      c_word_q  <= ram_data;
    end else if (accept && bus.req_we && hit) begin
      c_valid_q <= 1'b0;
    end
  end
`endif

  assign ram_data  = drive_q ? wdata_q : 32'bz;
  assign ram_addr  = addr_q;
  assign ram_be_n  = be_n_q;
  assign ram_ce_n  = ce_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;

  assign bus.rdata = rdata_q;
  assign bus.ready = (state_q == StDone);
  assign bus.busy  = (state_q != StIdle);

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised bench for sram_ctrl against a transaction-level memory model and a small SRAM.
module tb_sram_ctrl;

  localparam int unsigned RdCycles = 2;
  localparam int unsigned WrCycles = 2;
  localparam logic [31:0] Probe    = 32'hA5A5_5A5A;

  logic        clk;
  logic        rst;
  wire  [31:0] ram_data;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  sram_ctrl_if bus_if ();

  sram_ctrl #(
    .READ_CYCLES  (RdCycles),
    .WRITE_CYCLES (WrCycles)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_be_n (ram_be_n),
    .ram_ce_n (ram_ce_n),
    .ram_oe_n (ram_oe_n),
    .ram_we_n (ram_we_n)
  );

  int checks;
  int failures;

  logic [31:0] sram [256];
  logic [31:0] ref_mem [logic [19:0]];
  logic [31:0] last_rdata;
  logic [31:0] obs_rdata;
  bit          c_valid;
  logic [19:0] c_tag;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return {i, ~i, i ^ 8'h5A, 8'hC3};
  endfunction

  function automatic logic [31:0] model_read(input logic [19:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa[7:0]);
  endfunction

  // Board SRAM: drives on read enable, otherwise a probe pattern while deselected.
  assign ram_data = !ram_oe_n ? sram[ram_addr[7:0]] : (ram_ce_n ? Probe : 32'bz);

  always @(posedge clk) begin
    if (rst && !ram_ce_n && !ram_we_n) begin
      for (int b = 0; b < 4; b++) begin
        if (!ram_be_n[b]) sram[ram_addr[7:0]][8*b +: 8] <= ram_data[8*b +: 8];
      end
    end
  end

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input bit hold_req, input string tag);
    logic [19:0] wa;
    logic [31:0] exp_rd;
    logic [31:0] merged;
    bit          hit;
    int          lat;
    int          we_low;
    int          ce_low;
    wa  = addr[21:2];
    hit = 1'b0;
`ifdef SRAM_CTRL_READ_CACHE_EN
    hit = !we && c_valid && (c_tag == wa);
`endif
    lat    = we ? WrCycles + 3 : (hit ? 1 : RdCycles + 1);
    exp_rd = model_read(wa);
    we_low = 0;
    ce_low = 0;

    bus_if.req       = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_addr  = addr;
    bus_if.req_be    = be;
    bus_if.req_wdata = wdata;
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      checks++;
      if (!ram_oe_n && !ram_we_n) begin
        failures++;
        $display("FAIL %s oe_we_overlap k=%0d got oe_n=0 we_n=0 want never both low", tag, k);
      end
      if (ram_ce_n) begin
        checks++;
        if (ram_data !== Probe) begin
          failures++;
          $display("FAIL %s bus_released k=%0d got %h want %h", tag, k, ram_data, Probe);
        end
      end
      if (!ram_oe_n) begin
        checks++;
        if (ram_data !== sram[ram_addr[7:0]]) begin
          failures++;
          $display("FAIL %s read_bus k=%0d got %h want %h", tag, k, ram_data, sram[ram_addr[7:0]]);
        end
      end
      checks++;
      if (bus_if.ready !== (k == lat)) begin
        failures++;
        $display("FAIL %s ready k=%0d got %b want %b", tag, k, bus_if.ready, k == lat);
      end
      checks++;
      if (bus_if.busy !== (k <= lat)) begin
        failures++;
        $display("FAIL %s busy k=%0d got %b want %b", tag, k, bus_if.busy, k <= lat);
      end
      if (!ram_ce_n) ce_low++;
      if (!ram_we_n) begin
        we_low++;
        checks++;
        if (ram_addr !== wa || ram_be_n !== ~be || ram_data !== wdata) begin
          failures++;
          $display("FAIL %s write_pins k=%0d got addr=%h be_n=%b data=%h want addr=%h be_n=%b data=%h",
                   tag, k, ram_addr, ram_be_n, ram_data, wa, ~be, wdata);
        end
      end
      if (k == lat) begin
        obs_rdata = bus_if.rdata;
        checks++;
        if (bus_if.rdata !== (we ? last_rdata : exp_rd)) begin
          failures++;
          $display("FAIL %s rdata got %h want %h", tag, bus_if.rdata, we ? last_rdata : exp_rd);
        end
      end
      bus_if.req = hold_req && (k < lat);
      if (hold_req) begin
        bus_if.req_we    = 1'($urandom_range(0, 1));
        bus_if.req_addr  = $urandom();
        bus_if.req_wdata = $urandom();
      end
    end
    bus_if.req = 1'b0;
    checks++;
    if (we_low != (we ? WrCycles : 0)) begin
      failures++;
      $display("FAIL %s we_pulse_cycles got %0d want %0d", tag, we_low, we ? WrCycles : 0);
    end
    checks++;
    if (ce_low != (we ? WrCycles + 2 : (hit ? 0 : RdCycles))) begin
      failures++;
      $display("FAIL %s ce_cycles got %0d want %0d", tag, ce_low,
               we ? WrCycles + 2 : (hit ? 0 : RdCycles));
    end

    if (we) begin
      merged = model_read(wa);
      for (int b = 0; b < 4; b++) begin
        if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      end
      ref_mem[wa] = merged;
`ifdef SRAM_CTRL_READ_CACHE_EN
      if (c_valid && c_tag == wa) c_valid = 1'b0;
`endif
    end else begin
      last_rdata = exp_rd;
`ifdef SRAM_CTRL_READ_CACHE_EN
      c_valid = 1'b1;
      c_tag   = wa;
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ram_ce_n !== 1'b1 || ram_oe_n !== 1'b1 || ram_we_n !== 1'b1 || ram_be_n !== 4'b1111) begin
      failures++;
      $display("FAIL reset_strobes got ce_n=%b oe_n=%b we_n=%b be_n=%b want 1 1 1 1111",
               ram_ce_n, ram_oe_n, ram_we_n, ram_be_n);
    end
    checks++;
    if (ram_addr !== 20'h0 || bus_if.rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs got addr=%h rdata=%h want 0 0", ram_addr, bus_if.rdata);
    end
    checks++;
    if (bus_if.ready !== 1'b0 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got ready=%b busy=%b want 0 0", bus_if.ready, bus_if.busy);
    end
    checks++;
    if (ram_data !== Probe) begin
      failures++;
      $display("FAIL reset_bus got %h want %h", ram_data, Probe);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_txn(1'b1, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 1'b0, "basic_write");
    run_txn(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1'b0, "basic_read");
    checks++;
    if (obs_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL basic_value got %h want DEADBEEF", obs_rdata);
    end
  endtask

  task automatic test_byte_write();
    run_txn(1'b1, 32'h0000_0040, 4'b0010, 32'h0000_AA00, 1'b0, "byte_write");
    run_txn(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1'b0, "byte_read");
    checks++;
    if (obs_rdata !== 32'hDEAD_AAEF) begin
      failures++;
      $display("FAIL byte_value got %h want DEADAAEF", obs_rdata);
    end
  endtask

  task automatic test_zero_be();
    run_txn(1'b1, 32'hFFC0_0043, 4'b0000, 32'h1111_2222, 1'b0, "zero_be_write");
    run_txn(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1'b0, "zero_be_read");
  endtask

  // Request held high for the whole busy window: only the first one may be taken.
  task automatic test_busy_ignore();
    run_txn(1'b1, 32'h0000_0080, 4'b1111, 32'hCAFE_F00D, 1'b1, "busy_write");
    run_txn(1'b0, 32'h0000_0080, 4'b0000, 32'h0, 1'b0, "busy_read");
  endtask

  task automatic test_abort();
    bus_if.req       = 1'b1;
    bus_if.req_we    = 1'b1;
    bus_if.req_addr  = 32'h0000_03FC;
    bus_if.req_be    = 4'b1111;
    bus_if.req_wdata = 32'h0BAD_0BAD;
    @(posedge clk);
    @(negedge clk);
    bus_if.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_we_n !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_pulse got we_n=%b want 0", ram_we_n);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_we_n !== 1'b1 || ram_ce_n !== 1'b1 || ram_data !== Probe) begin
      failures++;
      $display("FAIL abort_release got we_n=%b ce_n=%b data=%h want 1 1 %h",
               ram_we_n, ram_ce_n, ram_data, Probe);
    end
    checks++;
    if (bus_if.ready !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.rdata !== 32'h0) begin
      failures++;
      $display("FAIL abort_status got ready=%b busy=%b rdata=%h want 0 0 0",
               bus_if.ready, bus_if.busy, bus_if.rdata);
    end
    rst = 1'b1;
    last_rdata = 32'h0;
    c_valid    = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_ready got %b want 0", bus_if.ready);
    end
  endtask

  task automatic test_cache();
    run_txn(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1'b0, "cache_read1");
    run_txn(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1'b0, "cache_read2");
    run_txn(1'b1, 32'h0000_0040, 4'b1111, 32'h1234_5678, 1'b0, "cache_write");
    run_txn(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 1'b0, "cache_read3");
    checks++;
    if (obs_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL cache_refresh got %h want 12345678", obs_rdata);
    end
  endtask

  task automatic test_random();
    logic [9:0]  hi;
    logic [1:0]  lo;
    logic [7:0]  w;
    logic        we;
    logic [3:0]  be;
    bit          hold;
    for (int n = 0; n < 60; n++) begin
      hi   = 10'($urandom_range(0, 1023));
      lo   = 2'($urandom_range(0, 3));
      w    = 8'($urandom_range(0, 15));
      we   = 1'($urandom_range(0, 1));
      be   = 4'($urandom_range(0, 15));
      hold = ($urandom_range(0, 3) == 0);
      run_txn(we, {hi, 12'h000, w, lo}, be, $urandom(), hold, we ? "rand_write" : "rand_read");
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    last_rdata       = 32'h0;
    obs_rdata        = 32'h0;
    c_valid          = 1'b0;
    c_tag            = '0;
    bus_if.req       = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_be    = '0;
    bus_if.req_wdata = '0;
    for (int i = 0; i < 256; i++) sram[i] <= init_word(8'(i));

    test_reset();
    test_basic();
    test_byte_write();
    test_zero_be();
    test_busy_ignore();
    test_abort();
    test_cache();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Upstream neighbour of the board SRAM model. Converts single-word CPU/bus memory requests into ThinPad-style asynchronous SRAM cycles on the shared ram_* pins.
- Runs a small FSM with programmable read/write pulse widths.
- Drives and releases the bidirectional ram_data bus.
- Returns read data with a one-cycle ready pulse.

Parameters:
- READ_CYCLES, 2, cycles ce_n/oe_n held low before read data is sampled (>=1)
- WRITE_CYCLES, 2, cycles ram_we_n held low per write (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- req  in  1  single-cycle request strobe; honoured only when busy=0
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address; word address = req_addr[21:2]
- req_be  in  4  byte enables, active-high (writes only)
- req_wdata  in  32  write data
- rdata  out  32  read data; valid while ready=1, held until next read completes
- ready  out  1  one-cycle completion pulse (reads and writes)
- busy  out  1  high whenever state != IDLE
- ram_data  inout  32  SRAM data; driven only in write states, else high-Z
- ram_addr  out  20  SRAM word address (Ram_addr_t)
- ram_be_n  out  4  byte enables, active-low
- ram_ce_n  out  1  chip select, active-low
- ram_oe_n  out  1  output enable, active-low
- ram_we_n  out  1  write enable, active-low

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, counter=0. ram_ce_n/oe_n/we_n=1, ram_be_n=4'b1111, ram_addr=0, ram_data high-Z, ready=0, rdata=0. All ram_* outputs are registered.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: req=1 at an edge latches we/addr/be/wdata and moves to RD (req_we=0) or WR_SETUP (req_we=1).
- RD: ce_n=0, oe_n=0, we_n=1, be_n=4'b0000, ram_data released. Lasts READ_CYCLES cycles. rdata is captured from ram_data at the edge ending the last RD cycle, then go to DONE.
- WR_SETUP: 1 cycle. ce_n=0, oe_n=1, we_n=1, be_n=~be, ram_addr and ram_data driven. Then WR_PULSE.
- WR_PULSE: WRITE_CYCLES cycles. Same as WR_SETUP but we_n=0. Then WR_HOLD.
- WR_HOLD: 1 cycle. we_n=1; ce_n, addr, be_n and data still held. Then DONE.
- DONE: 1 cycle. ready=1, all ram_* strobes deasserted, ram_data high-Z. Return to IDLE.
- Latency from accepting edge to ready: read = READ_CYCLES+1 cycles; write = WRITE_CYCLES+3 cycles.
- oe_n and we_n are never low in the same cycle.
- ram_data is never driven in RD, DONE or IDLE.
- req while busy=1 (including in DONE): ignored, no effect. Back-to-back requests are therefore at least latency+1 cycles apart.
- Write with be=4'b0000: full cycle runs with be_n=4'b1111, no bytes change, ready still pulses.
- req_addr[31:22] and [1:0] are ignored (wrap modulo 4 MB).
- Reset mid-operation: next edge forces IDLE and releases all strobes and ram_data. The transaction is aborted, ready is not asserted, and rdata keeps its previous value or 0.
- Counter width is $clog2(max(READ_CYCLES, WRITE_CYCLES)+1).

Optional Feature:
- Macro: SRAM_CTRL_READ_CACHE_EN. Adds a one-entry cache: valid bit, 20-bit tag, 32-bit word.
- With the macro, read request:
  - Hit (valid and tag equals req_addr[21:2]): IDLE goes straight to DONE, rdata = cached word, ready 1 cycle after accept. No SRAM cycle; ram_ce_n stays 1.
  - Miss: normal RD; on completion, fill the entry and set valid.
- With the macro, write:
  - A write to the cached word invalidates the entry.
  - Writes to other addresses leave it unchanged.
  - Reset clears valid.
- Without the macro: no cache state, and every read performs an SRAM cycle.

Decomposition:
- cpu_defines package: Word_t, Ram_addr_t, Mask_t, Bit_t, `HIGH_WORD (reused), plus a new sram_state_t enum for the six states.
- No sub-module: cache entry and FSM sit in one module. A tri-state bus keeper is unnecessary.

Test Plan:
- Write 0xDEADBEEF, addr 0x40, be=4'b1111 → ram_we_n low 2 cycles, ram_addr=0x10, ready at cycle 5. Read 0x40 → ready at cycle 3, rdata=0xDEADBEEF.
- Byte write: data 0x0000AA00, be=4'b0010 to 0x40, then read → rdata=0xDEADAAEF.
- Pulse req every cycle for 10 cycles (write to 0x80) → exactly one write cycle; extra reqs ignored while busy=1; one ready pulse.
- rst=0 in the second WR_PULSE cycle → next edge: ram_we_n=1, ram_ce_n=1, ram_data=Z, no ready.
- Bus check every cycle → ram_data never driven while ram_oe_n=0, and oe_n and we_n are never both low.
- With SRAM_CTRL_READ_CACHE_EN:
  - Read 0x40 twice → second read: ready 1 cycle after accept, ram_ce_n stays 1.
  - Write 0x40 = 0x12345678, then read → SRAM cycle occurs, rdata=0x12345678.
